pick_sequencer: RTL and testbench

- Game-board controller for the two-tile "pick A, pick B, add mod 10" mechanic.
- Owns the N-tile status board and converts debounced button levels into single press events.
- Sequences first-pick / second-pick selection, commits (A+B) mod 10 into the board, and counts moves.
- Sits between the per-button debouncers and the display/score logic.

---
 rtl/pick_pkg.sv | 25 ++
 rtl/press_arbiter.sv | 25 ++
 rtl/pick_sequencer.sv | 158 +++++++++++++++
 tb/tb_pick_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pick_pkg.sv
// Shared types and helpers for the pick/add game sequencer.
// Provides the FSM state enum, the "no tile" index and the mod-10 adder.
package pick_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PICKED,
    COMMIT
  } state_t;

  localparam logic [3:0] NONE_IDX = 4'hF;

  // 5-bit add with a single subtract of 10; out-of-range
  // inputs therefore wrap modulo 16 on the way out.
  function automatic logic [3:0] add_mod10(
    input logic [3:0] a,
    input logic [3:0] b
  );
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > 5'd9) s = s - 5'd10;
    return s[3:0];
  endfunction

endpackage

// File: rtl/press_arbiter.sv
// Lowest-index-wins encoder for the press event vector.
// Ports: press (N events) -> found flag, index (4'hF when none).
module press_arbiter
  import pick_pkg::*;
#(
  parameter int N = 10
) (
  input  logic [N-1:0] press,
  output logic         found,
  output logic [3:0]   index
);

  // Walk from the top down so the lowest set bit is written last.
  always_comb begin
    found = 1'b0;
    index = NONE_IDX;
    for (int i = N - 1; i >= 0; i--) begin
      if (press[i]) begin
        found = 1'b1;
        index = 4'(i);
      end
    end
  end

endmodule

// File: rtl/pick_sequencer.sv
// Board controller: pick tile A, pick tile B, write (A+B) mod 10 into B.
// Ports: clk, rst_n, enable, load/load_data, buttons -> status, sel_*, result*, move_count, busy.
module pick_sequencer
  import pick_pkg::*;
#(
  parameter int N       = 10,
  parameter int TIMEOUT = 50_000_000,
  parameter int MOVE_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              load,
  input  logic [N*4-1:0]    load_data,
  input  logic [N-1:0]      buttons,
  output logic [N*4-1:0]    status,
  output logic              sel_valid,
  output logic [3:0]        sel_index,
  output logic [3:0]        result,
  output logic              result_valid,
  output logic [MOVE_W-1:0] move_count,
  output logic              busy
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t            state, state_n;
  logic [N-1:0]      btn_q;
  logic [N-1:0]      press;
  logic              found;
  logic [3:0]        pidx;
  logic [TW-1:0]     timer, timer_n;
  logic [3:0]        b_val, b_n;
  logic [3:0]        tgt, tgt_n;
  logic [3:0]        tile_a, tile_p, sum;
  logic [N*4-1:0]    status_n;
  logic              sel_valid_n;
  logic [3:0]        sel_index_n;
  logic [3:0]        result_n;
  logic              rv_n;
  logic [MOVE_W-1:0] mc_n;

  assign press = buttons & ~btn_q;
  assign busy  = (state != IDLE);

  press_arbiter #(
    .N(N)
  ) u_arb (
    .press(press),
    .found(found),
    .index(pidx)
  );

  // Tile A is the held selection; tile_p is the tile just pressed.
  always_comb begin
    tile_a = 4'h0;
    tile_p = 4'h0;
    for (int i = 0; i < N; i++) begin
      if (4'(i) == sel_index) tile_a = status[i*4+:4];
      if (4'(i) == pidx)      tile_p = status[i*4+:4];
    end
  end

  assign sum = add_mod10(tile_a, b_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      btn_q        <= '0;
      timer        <= '0;
      b_val        <= 4'h0;
      tgt          <= NONE_IDX;
      status       <= '0;
      sel_valid    <= 1'b0;
      sel_index    <= NONE_IDX;
      result       <= 4'h0;
      result_valid <= 1'b0;
      move_count   <= '0;
    end else begin
      state        <= state_n;
      btn_q        <= buttons;
      timer        <= timer_n;
      b_val        <= b_n;
      tgt          <= tgt_n;
      status       <= status_n;
      sel_valid    <= sel_valid_n;
      sel_index    <= sel_index_n;
      result       <= result_n;
      result_valid <= rv_n;
      move_count   <= mc_n;
    end
  end

  always_comb begin
    state_n     = state;
    timer_n     = timer;
    b_n         = b_val;
    tgt_n       = tgt;
    status_n    = status;
    sel_valid_n = sel_valid;
    sel_index_n = sel_index;
    result_n    = result;
    rv_n        = 1'b0;
    mc_n        = move_count;

    if (load) begin
      status_n    = load_data;
      state_n     = IDLE;
      timer_n     = '0;
      sel_valid_n = 1'b0;
      sel_index_n = NONE_IDX;
      mc_n        = '0;
    end else if (enable) begin
      unique case (state)
        IDLE: begin
          if (found && tile_p != 4'h0) begin
            sel_valid_n = 1'b1;
            sel_index_n = pidx;
            timer_n     = '0;
            state_n     = PICKED;
          end
        end
        PICKED: begin
          timer_n = timer + 1'b1;
          if (found) begin
            if (pidx == sel_index) begin
              sel_valid_n = 1'b0;
              sel_index_n = NONE_IDX;
              state_n     = IDLE;
            end else begin
              b_n     = tile_p;
              tgt_n   = pidx;
              state_n = COMMIT;
            end
          end else if (timer == TW'(TIMEOUT - 1)) begin
            sel_valid_n = 1'b0;
            sel_index_n = NONE_IDX;
            state_n     = IDLE;
          end
        end
        COMMIT: begin
          for (int i = 0; i < N; i++) begin
            if (4'(i) == tgt)       status_n[i*4+:4] = sum;
            if (4'(i) == sel_index) status_n[i*4+:4] = 4'h0;
          end
          result_n    = sum;
          rv_n        = 1'b1;
          if (move_count != '1) mc_n = move_count + 1'b1;
          sel_valid_n = 1'b0;
          sel_index_n = NONE_IDX;
          state_n     = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pick_sequencer.sv
// Directed bench for pick_sequencer (N=4, TIMEOUT=8).
// Commit results are queued at stimulus time and checked on result_valid.
module tb_pick_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic [15:0] load_data;
  logic [3:0]  buttons;
  logic [15:0] status;
  logic        sel_valid;
  logic [3:0]  sel_index;
  logic [3:0]  result;
  logic        result_valid;
  logic [7:0]  move_count;
  logic        busy;

  typedef struct {
    logic [15:0] st;
    logic [3:0]  res;
    logic [7:0]  mc;
  } exp_t;

  exp_t sb[$];
  int   total    = 0;
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   rv_cnt   = 0;

  always #5 clk = ~clk;

  pick_sequencer #(
    .N(4),
    .TIMEOUT(8),
    .MOVE_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .load(load),
    .load_data(load_data),
    .buttons(buttons),
    .status(status),
    .sel_valid(sel_valid),
    .sel_index(sel_index),
    .result(result),
    .result_valid(result_valid),
    .move_count(move_count),
    .busy(busy)
  );

  function automatic logic [15:0] brd(
    int t0, int t1, int t2, int t3
  );
    return {4'(t3), 4'(t2), 4'(t1), 4'(t0)};
  endfunction

  function automatic logic [3:0] m10(int a, int b);
    return 4'((a + b) % 10);
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pressm(input logic [3:0] m);
    buttons = m;
    tick();
    buttons = 4'b0;
  endtask

  task automatic press(input int i);
    pressm(4'(1 << i));
  endtask

  task automatic do_load(input logic [15:0] d);
    load      = 1'b1;
    load_data = d;
    tick();
    load      = 1'b0;
  endtask

  task automatic push(
    input logic [15:0] st,
    input logic [3:0]  res,
    input logic [7:0]  mc
  );
    exp_t e;
    e.st  = st;
    e.res = res;
    e.mc  = mc;
    sb.push_back(e);
  endtask

  // Scoreboard side: every commit pulse pops one expectation.
  always @(negedge clk) begin
    if (rst_n && result_valid) begin
      rv_cnt++;
      if (sb.size() == 0) begin
        chk("sb_unexpected_commit", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_status", 32'(status), 32'(e.st));
        chk("sb_result", 32'(result), 32'(e.res));
        chk("sb_moves", 32'(move_count), 32'(e.mc));
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b1;
    load      = 1'b0;
    load_data = '0;
    buttons   = '0;
    tick();
    tick();
    chk("rst_status", 32'(status), 32'h0);
    chk("rst_sel_valid", 32'(sel_valid), 32'h0);
    chk("rst_sel_index", 32'(sel_index), 32'hF);
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_rv", 32'(result_valid), 32'h0);
    chk("rst_moves", 32'(move_count), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    tick();

    // 3 + 7 -> 0
    do_load(brd(3, 7, 0, 5));
    chk("load1_status", 32'(status), 32'(brd(3, 7, 0, 5)));
    press(0);
    chk("a_sel_valid", 32'(sel_valid), 32'h1);
    chk("a_sel_index", 32'(sel_index), 32'h0);
    push(brd(0, 0, 0, 5), m10(3, 7), 8'd1);
    press(1);
    chk("b_busy", 32'(busy), 32'h1);
    chk("b_board_held", 32'(status), 32'(brd(3, 7, 0, 5)));
    tick();
    chk("c1_rv", 32'(result_valid), 32'h1);
    chk("c1_status", 32'(status), 32'(brd(0, 0, 0, 5)));
    chk("c1_sel_index", 32'(sel_index), 32'hF);
    tick();
    chk("c1_rv_pulse", 32'(result_valid), 32'h0);
    chk("c1_busy", 32'(busy), 32'h0);

    // 4 + 8 -> 2
    do_load(brd(4, 8, 1, 2));
    press(0);
    push(brd(0, 2, 1, 2), m10(4, 8), 8'd1);
    press(1);
    tick();
    chk("c2_status", 32'(status), 32'(brd(0, 2, 1, 2)));
    tick();

    // Zero tile is not selectable
    do_load(brd(1, 2, 0, 3));
    chk("load3_moves", 32'(move_count), 32'h0);
    press(2);
    chk("zero_sel_valid", 32'(sel_valid), 32'h0);
    chk("zero_busy", 32'(busy), 32'h0);
    tick();

    // Same tile twice deselects
    press(0);
    chk("dsel_a", 32'(sel_valid), 32'h1);
    tick();
    press(0);
    chk("dsel_valid", 32'(sel_valid), 32'h0);
    chk("dsel_index", 32'(sel_index), 32'hF);
    chk("dsel_board", 32'(status), 32'(brd(1, 2, 0, 3)));
    chk("dsel_moves", 32'(move_count), 32'h0);

    // Simultaneous t1/t3: lowest wins, t3 dropped
    pressm(4'b1010);
    chk("multi_index", 32'(sel_index), 32'h1);
    tick();
    chk("multi_drop_busy", 32'(busy), 32'h1);
    chk("multi_drop_idx", 32'(sel_index), 32'h1);
    press(1);
    chk("multi_desel", 32'(sel_valid), 32'h0);
    tick();

    // Timeout after 8 held cycles
    press(0);
    for (int k = 0; k < 7; k++) tick();
    chk("to_held", 32'(sel_valid), 32'h1);
    tick();
    chk("to_expired", 32'(sel_valid), 32'h0);
    chk("to_index", 32'(sel_index), 32'hF);

    // Press on the timeout cycle wins
    press(0);
    for (int k = 0; k < 7; k++) tick();
    push(brd(0, 3, 0, 3), m10(1, 2), 8'd1);
    press(1);
    chk("to_race_busy", 32'(busy), 32'h1);
    tick();
    chk("to_race_result", 32'(result), 32'h3);
    tick();

    // enable low: press ignored
    enable = 1'b0;
    press(1);
    chk("en_ignored", 32'(sel_valid), 32'h0);
    enable = 1'b1;
    tick();

    // Load while PICKED
    press(3);
    chk("ld_pick", 32'(sel_index), 32'h3);
    do_load(brd(9, 9, 4, 6));
    chk("ld_status", 32'(status), 32'(brd(9, 9, 4, 6)));
    chk("ld_busy", 32'(busy), 32'h0);
    chk("ld_sel_index", 32'(sel_index), 32'hF);
    chk("ld_moves", 32'(move_count), 32'h0);
    chk("ld_result", 32'(result), 32'h3);

    // 9 + 9 -> 8
    press(0);
    push(brd(0, 8, 4, 6), m10(9, 9), 8'd1);
    press(1);
    tick();
    tick();

    // Async reset during COMMIT
    press(2);
    press(3);
    chk("rc_busy", 32'(busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_status", 32'(status), 32'h0);
    chk("ar_sel_valid", 32'(sel_valid), 32'h0);
    chk("ar_sel_index", 32'(sel_index), 32'hF);
    chk("ar_result", 32'(result), 32'h0);
    chk("ar_moves", 32'(move_count), 32'h0);
    chk("ar_busy", 32'(busy), 32'h0);
    tick();
    tick();
    chk("ar_no_rv", 32'(result_valid), 32'h0);
    rst_n = 1'b1;
    tick();

    chk("sb_drained", 32'(sb.size()), 32'h0);
    chk("commit_pulses", 32'(rv_cnt), 32'd4);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
